ram_copy_engine: RTL and testbench

Initiator-side sequencer for the 16×8 scratch RAM. It accepts a one-shot copy command (source, destination, length) and drives the RAM's read and write ports to move bytes forward, one at a time. It also accumulates an 8-bit checksum of the bytes moved. It sits between control logic (or a host register file) and the RAM, so nothing else needs to sequence RAM accesses for block moves.

---
 rtl/ram_copy_engine.sv | 101 ++++++++++
 tb/tb_ram_copy_engine.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_copy_engine.sv
// Block-copy sequencer for the scratch RAM: moves one byte per three cycles,
// in forward order, and keeps a running modular checksum of the bytes written.
module ram_copy_engine #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   count,
    output logic [DATA_W-1:0] checksum,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_read_addr,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_write_addr,
    output logic [DATA_W-1:0] mem_write_data
);

    // state | meaning
    // IDLE  | waiting for start
    // RD    | read strobe for byte[count]
    // CAP   | capture read data, set write address
    // WR    | write strobe, advance count/checksum
    // DONE  | one-cycle completion pulse
    typedef enum logic [2:0] {IDLE, RD, CAP, WR, DONE} state_t;

    localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   len_clamped;
    logic [ADDR_W:0]   count_next;

    assign len_clamped = (length > MAX_LEN) ? MAX_LEN : length;
    assign count_next  = count + ONE;

    // Strobes come straight from the state register so they cannot glitch.
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign mem_read  = (state == RD);
    assign mem_write = (state == WR);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            src_q          <= '0;
            dst_q          <= '0;
            len_q          <= '0;
            count          <= '0;
            checksum       <= '0;
            mem_read_addr  <= '0;
            mem_write_addr <= '0;
            mem_write_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        src_q         <= src_addr;
                        dst_q         <= dst_addr;
                        len_q         <= len_clamped;
                        count         <= '0;
                        checksum      <= '0;
                        mem_read_addr <= src_addr;
                        state         <= (len_clamped == '0) ? DONE : RD;
                    end
                end
                RD: begin
                    state <= CAP;
                end
                CAP: begin
                    mem_write_data <= mem_read_data;
                    mem_write_addr <= dst_q + count[ADDR_W-1:0];
                    state          <= WR;
                end
                WR: begin
                    count         <= count_next;
                    checksum      <= checksum + mem_write_data;
                    // Next read address is prepared here so RD can strobe it directly.
                    mem_read_addr <= src_q + count_next[ADDR_W-1:0];
                    state         <= (count_next == len_q) ? DONE : RD;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_copy_engine.sv
// Scoreboard bench for ram_copy_engine with a behavioural 16x8 RAM model;
// expected reads, writes and completions are queued by the stimulus.
module tb_ram_copy_engine;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [3:0] src_addr = '0;
    logic [3:0] dst_addr = '0;
    logic [4:0] length = '0;
    logic       busy;
    logic       done;
    logic [4:0] count;
    logic [7:0] checksum;
    logic       mem_read;
    logic [3:0] mem_read_addr;
    logic [7:0] mem_read_data = '0;
    logic       mem_write;
    logic [3:0] mem_write_addr;
    logic [7:0] mem_write_data;

    logic [7:0] ram [16];

    typedef struct {
        int cnt;
        int cks;
        int cyc;
    } done_t;

    int    exp_rd[$];
    int    exp_wa[$];
    int    exp_wd[$];
    done_t exp_done[$];

    int n_total = 0;
    int n_pass  = 0;
    int busy_cnt = 0;
    logic prev_done = 1'b0;

    ram_copy_engine #(.ADDR_W(4), .DATA_W(8)) dut (
        .clock(clock), .reset(reset), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
        .busy(busy), .done(done), .count(count), .checksum(checksum),
        .mem_read(mem_read), .mem_read_addr(mem_read_addr), .mem_read_data(mem_read_data),
        .mem_write(mem_write), .mem_write_addr(mem_write_addr), .mem_write_data(mem_write_data)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (mem_read) mem_read_data <= ram[mem_read_addr];
        if (mem_write) ram[mem_write_addr] = mem_write_data;
    end

    function automatic void check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endfunction

    // Monitor: compares every RAM access and completion against the queues.
    always @(negedge clock) begin
        if (reset || !busy) busy_cnt = 0;
        else busy_cnt++;
        if (prev_done) check("busy_after_done", int'(busy), 0);
        prev_done = done && !reset;
        if (mem_read || mem_write) check("rd_wr_exclusive", int'(mem_read & mem_write), 0);
        if (mem_read) begin
            check("read_expected", int'(exp_rd.size() > 0), 1);
            if (exp_rd.size() > 0) check("read_addr", int'(mem_read_addr), exp_rd.pop_front());
        end
        if (mem_write) begin
            check("write_expected", int'(exp_wa.size() > 0), 1);
            if (exp_wa.size() > 0) begin
                check("write_addr", int'(mem_write_addr), exp_wa.pop_front());
                check("write_data", int'(mem_write_data), exp_wd.pop_front());
            end
        end
        if (done) begin
            check("done_expected", int'(exp_done.size() > 0), 1);
            if (exp_done.size() > 0) begin
                done_t e;
                e = exp_done.pop_front();
                check("done_count", int'(count), e.cnt);
                check("done_checksum", int'(checksum), e.cks);
                check("done_cycle", busy_cnt, e.cyc);
            end
        end
    end

    task automatic issue_cmd(input int s, input int d, input int l);
        @(negedge clock);
        src_addr = 4'(s);
        dst_addr = 4'(d);
        length   = 5'(l);
        start    = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic expect_done(input int cnt, input int cks);
        done_t e;
        e.cnt = cnt;
        e.cks = cks;
        e.cyc = (cnt == 0) ? 1 : 3 * cnt + 1;
        exp_done.push_back(e);
    endtask

    task automatic wait_done(input int cnt, input int cks);
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            #1;
            if (exp_done.size() == 0) break;
        end
        check("done_timeout", exp_done.size(), 0);
        check("rd_queue_drained", exp_rd.size(), 0);
        check("wr_queue_drained", exp_wa.size(), 0);
        exp_done.delete();
        exp_rd.delete();
        exp_wa.delete();
        exp_wd.delete();
        repeat (2) @(negedge clock);
        #1;
        check("count_hold", int'(count), cnt);
        check("checksum_hold", int'(checksum), cks);
    endtask

    task automatic push_rw(input int ra, input int wa, input int wd);
        exp_rd.push_back(ra);
        exp_wa.push_back(wa);
        exp_wd.push_back(wd);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ram[i] = 8'h00;
        repeat (2) @(negedge clock);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_mem_read", int'(mem_read), 0);
        check("rst_mem_write", int'(mem_write), 0);
        check("rst_count", int'(count), 0);
        check("rst_checksum", int'(checksum), 0);
        check("rst_wdata", int'(mem_write_data), 0);
        reset = 1'b0;

        // Basic copy 0..3 -> 8..11
        ram[0] = 8'h11; ram[1] = 8'h22; ram[2] = 8'h33; ram[3] = 8'h44;
        push_rw(0, 8, 8'h11); push_rw(1, 9, 8'h22); push_rw(2, 10, 8'h33); push_rw(3, 11, 8'h44);
        expect_done(4, 8'hAA);
        issue_cmd(0, 8, 4);
        check("first_cycle_read", int'(mem_read), 1);
        wait_done(4, 8'hAA);
        check("t1_ram8", int'(ram[8]), 8'h11);
        check("t1_ram11", int'(ram[11]), 8'h44);

        // Source wrap 14,15,0 -> 2..4
        ram[14] = 8'h01; ram[15] = 8'h02; ram[0] = 8'h03;
        push_rw(14, 2, 8'h01); push_rw(15, 3, 8'h02); push_rw(0, 4, 8'h03);
        expect_done(3, 8'h06);
        issue_cmd(14, 2, 3);
        wait_done(3, 8'h06);
        check("wrap_ram2", int'(ram[2]), 8'h01);
        check("wrap_ram4", int'(ram[4]), 8'h03);

        // Zero length: single-cycle busy/done, no RAM access
        expect_done(0, 0);
        issue_cmd(3, 7, 0);
        wait_done(0, 0);

        // Overlap dst = src+1 replicates the first byte
        ram[5] = 8'h7F;
        push_rw(5, 6, 8'h7F); push_rw(6, 7, 8'h7F); push_rw(7, 8, 8'h7F);
        expect_done(3, 8'h7D);
        issue_cmd(5, 6, 3);
        wait_done(3, 8'h7D);
        check("ovl_ram8", int'(ram[8]), 8'h7F);

        // Length 20 clamps to 16; in-place copy of the whole RAM
        for (int i = 0; i < 16; i++) ram[i] = 8'(8'h10 + i);
        for (int i = 0; i < 16; i++) push_rw(i, i, 8'h10 + i);
        expect_done(16, 8'h78);
        issue_cmd(0, 0, 20);
        wait_done(16, 8'h78);
        check("clamp_ram15", int'(ram[15]), 8'h1F);

        // Start pulsed mid-copy must be ignored
        ram[0] = 8'h11; ram[1] = 8'h22; ram[2] = 8'h33; ram[3] = 8'h44;
        for (int i = 8; i < 12; i++) ram[i] = 8'h00;
        push_rw(0, 8, 8'h11); push_rw(1, 9, 8'h22); push_rw(2, 10, 8'h33); push_rw(3, 11, 8'h44);
        expect_done(4, 8'hAA);
        issue_cmd(0, 8, 4);
        repeat (3) @(negedge clock);
        src_addr = 4'd9; dst_addr = 4'd3; length = 5'd2; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_done(4, 8'hAA);
        check("ign_ram10", int'(ram[10]), 8'h33);
        check("ign_ram3", int'(ram[3]), 8'h44);

        // Reset during CAP of byte index 2
        for (int i = 8; i < 12; i++) ram[i] = 8'hEE;
        exp_rd.push_back(0); exp_rd.push_back(1); exp_rd.push_back(2);
        exp_wa.push_back(8); exp_wd.push_back(8'h11);
        exp_wa.push_back(9); exp_wd.push_back(8'h22);
        issue_cmd(0, 8, 4);
        repeat (7) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_count", int'(count), 0);
        check("mid_rst_checksum", int'(checksum), 0);
        check("mid_rst_wdata", int'(mem_write_data), 0);
        check("mid_rst_waddr", int'(mem_write_addr), 0);
        check("mid_rst_raddr", int'(mem_read_addr), 0);
        check("mid_rst_strobes", int'({mem_read, mem_write, done}), 0);
        @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        #1;
        check("mid_rst_reads_done", exp_rd.size(), 0);
        check("mid_rst_writes_done", exp_wa.size(), 0);
        check("mid_rst_ram10_kept", int'(ram[10]), 8'hEE);
        check("mid_rst_ram9", int'(ram[9]), 8'h22);

        // Fresh command after reset
        ram[4] = 8'h5A; ram[5] = 8'hA5;
        push_rw(4, 12, 8'h5A); push_rw(5, 13, 8'hA5);
        expect_done(2, 8'hFF);
        issue_cmd(4, 12, 2);
        wait_done(2, 8'hFF);
        check("post_ram12", int'(ram[12]), 8'h5A);
        check("post_ram13", int'(ram[13]), 8'hA5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
